sobel_edge_3x3: RTL and testbench
=================================

Name: sobel_edge_3x3

Overview:
- Downstream consumer of the 3x3 window generator in the DVP video-processing chain.
- Takes the nine window pixels plus the window vs/de, computes an approximate Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline, and emits one 8-bit result per valid pixel.
- The result is either the saturated magnitude or a binarised edge map.
- Threshold and mode are frame-synchronous: they only change at a frame start, so a frame is never processed with mixed settings.

Parameters:
- THRESH_DEFAULT, 8'd64, threshold value in effect from reset until the first frame start.
- MODE_DEFAULT, 1'b0, bin_en value in effect from reset until the first frame start.

Ports:
- clk  input  1  pixel clock, shared with the window generator.
- rst_n  input  1  asynchronous, active-low reset.
- matrix_vs  input  1  frame sync from the window generator.
- matrix_de  input  1  window-valid strobe.
- matrix_p11..matrix_p33  input  8 each  3x3 window; row 1 is the oldest line, column 1 is the oldest pixel.
- threshold  input  8  edge threshold; sampled at frame start.
- bin_en  input  1  1 = binary output, 0 = magnitude output; sampled at frame start.
- post_vs  output  1  matrix_vs delayed 3 clocks.
- post_de  output  1  matrix_de delayed 3 clocks.
- post_data  output  8  edge result.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All pipeline registers, post_vs, post_de and post_data go to 0.
  - thr_q = THRESH_DEFAULT, mode_q = MODE_DEFAULT.
  - vs_prev (1-bit history of matrix_vs) = 0.
- Frame-start latch:
  - Frame start = matrix_vs == 1 && vs_prev == 0 on a clock edge.
  - On that edge, thr_q <= threshold and mode_q <= bin_en.
  - Otherwise thr_q and mode_q hold. Changes to threshold or bin_en mid-frame have no effect until the next frame start.
- Pipeline: registers advance every clock, not gated by de.
  - Stage 1: compute four unsigned 10-bit sums:
    - gx_p = p13 + 2*p23 + p33
    - gx_n = p11 + 2*p21 + p31
    - gy_p = p11 + 2*p12 + p13
    - gy_n = p31 + 2*p32 + p33
    - Maximum of each is 1020; no overflow.
  - Stage 2: gx_abs = |gx_p - gx_n| and gy_abs = |gy_p - gy_n|, each 10 bits unsigned. Compute by comparing, then subtracting larger minus smaller; no signed wrap.
  - Stage 3: mag = gx_abs + gy_abs, 11 bits, max 2040.
    - sat = (mag > 255) ? 255 : mag[7:0].
    - mode_q == 0: post_data <= sat.
    - mode_q == 1: post_data <= (mag >= thr_q) ? 8'd255 : 8'd0. The comparison uses the full 11-bit mag, not sat.
- Output masking: if the de bit entering stage 3 (matrix_de delayed 2) is 0, post_data <= 0. post_data is 0 whenever post_de is 0.
- Latency:
  - Window sampled at edge N appears on post_data at edge N+3, aligned with post_de.
  - post_vs and post_de are 3-stage shift registers of matrix_vs and matrix_de.
- Settings alignment: thr_q and mode_q are read at stage 3. Windows already in flight when a frame start occurs use the new settings. This is acceptable because vs rises during blanking while de = 0.
- Simultaneous events: frame start coincident with matrix_de = 1 still latches; the pipeline is unaffected.
- Reset mid-frame: outputs go to 0 immediately. After release, output is valid again 3 clocks after the first de. Settings revert to defaults until the next frame start.
- Back-to-back de with no gaps: one result per clock, no stalls, no backpressure.

Test Plan:
1. Flat window, all nine pixels 100, de = 1, mode 0 -> post_data = 0 exactly 3 clocks later, post_de = 1 on that same clock.
2. Vertical edge: column 1 = 0, column 3 = 255, column 2 = 128 in all rows, mode 0 -> gx = 1020, gy = 0, post_data = 255 (saturated).
3. Only p13 = 10, others 0, mode 0 -> post_data = 20. Same window with mode 1:
   - thr = 20 -> 255.
   - thr = 21 -> 0.
4. Frame-synchronous latch:
   - threshold = 21 in frame A, changed to 20 mid-frame while vs stays high -> p13 = 10 window keeps producing 0.
   - After the next vs rising edge -> produces 255.
5. Continuous de with alternating windows of case 2 and case 1 -> output alternates 255, 0 every clock with 3-cycle latency. de gap of 1 -> post_de = 0 and post_data = 0 on exactly one clock.
6. Assert rst_n low mid-stream -> post_vs = post_de = post_data = 0 asynchronously. After release, with no vs edge, mode 1 uses THRESH_DEFAULT = 64: a magnitude-64 window -> 255, a magnitude-63 window -> 0.

Source files
------------

// File: rtl/sobel_edge_3x3_if.sv
// Window-in / result-out bus between the 3x3 window generator, the Sobel stage and its consumer.
// The master drives the window and reads the result; the slave is the Sobel stage.
interface sobel_edge_3x3_if;
    logic       matrix_vs;
    logic       matrix_de;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic       post_vs;
    logic       post_de;
    logic [7:0] post_data;

    modport master (
        output matrix_vs, matrix_de,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        input  post_vs, post_de, post_data
    );

    modport slave (
        input  matrix_vs, matrix_de,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        output post_vs, post_de, post_data
    );
endinterface

// File: rtl/sobel_edge_3x3.sv
// Sobel |Gx|+|Gy| edge magnitude or thresholded edge map, one result per window; 3-clock latency.
// Free-running pipeline: no stalls and no backpressure, threshold/mode latched on each vs rising edge.
module sobel_edge_3x3 #(
    parameter logic [7:0] THRESH_DEFAULT = 8'd64,
    parameter logic       MODE_DEFAULT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    sobel_edge_3x3_if.slave  win,
    input  logic [7:0]       threshold,
    input  logic             bin_en
);

    function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic       vs_prev;
    logic [7:0] thr_q;
    logic       mode_q;
    logic       frame_start;

    logic [9:0] gx_p, gx_n, gy_p, gy_n;
    logic [9:0] gx_abs, gy_abs;
    logic [2:0] vs_pipe;
    logic [2:0] de_pipe;
    logic [7:0] post_data_q;

    logic [10:0] mag;
    logic [7:0]  sat;
    logic [7:0]  result;

    assign frame_start = win.matrix_vs & ~vs_prev;

    // Settings move only at frame start so a frame never mixes thresholds or modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= 1'b0;
            thr_q   <= THRESH_DEFAULT;
            mode_q  <= MODE_DEFAULT;
        end else begin
            vs_prev <= win.matrix_vs;
            if (frame_start) begin
                thr_q  <= threshold;
                mode_q <= bin_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_p    <= '0;
            gx_n    <= '0;
            gy_p    <= '0;
            gy_n    <= '0;
            gx_abs  <= '0;
            gy_abs  <= '0;
            vs_pipe <= '0;
            de_pipe <= '0;
        end else begin
            gx_p    <= tap_sum(win.matrix_p13, win.matrix_p23, win.matrix_p33);
            gx_n    <= tap_sum(win.matrix_p11, win.matrix_p21, win.matrix_p31);
            gy_p    <= tap_sum(win.matrix_p11, win.matrix_p12, win.matrix_p13);
            gy_n    <= tap_sum(win.matrix_p31, win.matrix_p32, win.matrix_p33);
            gx_abs  <= abs_diff(gx_p, gx_n);
            gy_abs  <= abs_diff(gy_p, gy_n);
            vs_pipe <= {vs_pipe[1:0], win.matrix_vs};
            de_pipe <= {de_pipe[1:0], win.matrix_de};
        end
    end

    // Binary mode compares the unsaturated magnitude so thresholds act on the true gradient.
    always_comb begin
        mag    = {1'b0, gx_abs} + {1'b0, gy_abs};
        sat    = (mag > 11'd255) ? 8'hFF : mag[7:0];
        result = 8'h00;
        if (de_pipe[1]) begin
            if (mode_q) begin
                result = (mag >= {3'b000, thr_q}) ? 8'hFF : 8'h00;
            end else begin
                result = sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_data_q <= '0;
        end else begin
            post_data_q <= result;
        end
    end

    assign win.post_vs   = vs_pipe[2];
    assign win.post_de   = de_pipe[2];
    assign win.post_data = post_data_q;

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Directed and randomized stimulus for sobel_edge_3x3, checked against a cycle-level reference.
module tb_sobel_edge_3x3;

    typedef logic [2:0][2:0][7:0] win_t;   // [row][col], row 0 = oldest line
    typedef struct packed {
        logic vs;
        logic de;
        win_t pix;
    } hist_t;

    localparam logic [7:0] DEF_THR  = 8'd64;
    localparam logic       DEF_MODE = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] threshold;
    logic       bin_en;
    logic       cur_vs;
    logic       cur_de;
    win_t       w;

    int errors = 0;
    int checks = 0;

    hist_t      hist[$];
    logic [7:0] thr_m;
    logic       mode_m;
    logic       vs_prev_m;

    always #5 clk = ~clk;

    sobel_edge_3x3_if bus ();

    assign bus.matrix_vs  = cur_vs;
    assign bus.matrix_de  = cur_de;
    assign bus.matrix_p11 = w[0][0];
    assign bus.matrix_p12 = w[0][1];
    assign bus.matrix_p13 = w[0][2];
    assign bus.matrix_p21 = w[1][0];
    assign bus.matrix_p22 = w[1][1];
    assign bus.matrix_p23 = w[1][2];
    assign bus.matrix_p31 = w[2][0];
    assign bus.matrix_p32 = w[2][1];
    assign bus.matrix_p33 = w[2][2];

    sobel_edge_3x3 #(
        .THRESH_DEFAULT (DEF_THR),
        .MODE_DEFAULT   (DEF_MODE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .win       (bus.slave),
        .threshold (threshold),
        .bin_en    (bin_en)
    );

    function automatic int px(input win_t p, input int r, input int c);
        return int'(p[r][c]);
    endfunction

    function automatic logic [7:0] ref_out(input win_t p, input logic [7:0] thr, input logic mode);
        int gx, gy, mag;
        gx = (px(p,0,2) + 2*px(p,1,2) + px(p,2,2)) - (px(p,0,0) + 2*px(p,1,0) + px(p,2,0));
        gy = (px(p,0,0) + 2*px(p,0,1) + px(p,0,2)) - (px(p,2,0) + 2*px(p,2,1) + px(p,2,2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        if (mode) return (mag >= int'(thr)) ? 8'd255 : 8'd0;
        return (mag > 255) ? 8'd255 : 8'(mag);
    endfunction

    function automatic win_t win_flat(input logic [7:0] v);
        win_t t;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) t[r][c] = v;
        return t;
    endfunction

    function automatic win_t win_vert();
        win_t t;
        for (int r = 0; r < 3; r++) begin
            t[r][0] = 8'd0;
            t[r][1] = 8'd128;
            t[r][2] = 8'd255;
        end
        return t;
    endfunction

    function automatic win_t win_corner(input logic [7:0] v);
        win_t t;
        t = '0;
        t[0][2] = v;
        return t;
    endfunction

    function automatic logic [7:0] rand_pix(input int kind, input logic [7:0] base);
        if (kind == 0) return 8'($urandom_range(0, 255));
        if (kind == 1) return ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
        return base + 8'($urandom_range(0, 40));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        thr_m     = DEF_THR;
        mode_m    = DEF_MODE;
        vs_prev_m = 1'b0;
    endtask

    // One clock: predict what this edge produces, advance the model, then compare.
    task automatic tick();
        hist_t      h;
        hist_t      e;
        logic       exp_vs;
        logic       exp_de;
        logic [7:0] exp_data;
        h.vs  = cur_vs;
        h.de  = cur_de;
        h.pix = w;
        hist.push_back(h);
        if (hist.size() > 3) void'(hist.pop_front());
        exp_vs = 1'b0; exp_de = 1'b0; exp_data = 8'd0;
        if (hist.size() == 3) begin
            e        = hist[0];
            exp_vs   = e.vs;
            exp_de   = e.de;
            exp_data = e.de ? ref_out(e.pix, thr_m, mode_m) : 8'd0;
        end
        if (cur_vs && !vs_prev_m) begin
            thr_m  = threshold;
            mode_m = bin_en;
        end
        vs_prev_m = cur_vs;
        @(posedge clk);
        #1;
        check("post_vs",   32'(bus.post_vs),   32'(exp_vs));
        check("post_de",   32'(bus.post_de),   32'(exp_de));
        check("post_data", 32'(bus.post_data), 32'(exp_data));
    endtask

    task automatic frame_start(input logic [7:0] thr, input logic mode);
        cur_de = 1'b0;
        cur_vs = 1'b0;
        tick();
        threshold = thr;
        bin_en    = mode;
        cur_vs    = 1'b1;
        tick();
        tick();
    endtask

    // Single window then blanking; the result is visible after the third edge.
    task automatic run_one(input win_t win, input string tag, input logic [7:0] exp);
        w      = win;
        cur_de = 1'b1;
        tick();
        cur_de = 1'b0;
        w      = '0;
        tick();
        check({tag, "_de_early"}, 32'(bus.post_de), 32'd0);
        tick();
        check({tag, "_data"}, 32'(bus.post_data), 32'(exp));
        check({tag, "_de"},   32'(bus.post_de),   32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cur_vs    = 1'b0;
        cur_de    = 1'b0;
        w         = '0;
        threshold = 8'd0;
        bin_en    = 1'b0;
        model_reset();
        #12;
        check("rst_vs",   32'(bus.post_vs),   32'd0);
        check("rst_de",   32'(bus.post_de),   32'd0);
        check("rst_data", 32'(bus.post_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults before any frame start: binary mode at threshold 64.
        run_one(win_corner(8'd32), "dflt_mag64", 8'd255);
        run_one(win_corner(8'd31), "dflt_mag62", 8'd0);

        frame_start(8'd64, 1'b0);
        run_one(win_flat(8'd100), "flat",      8'd0);
        run_one(win_vert(),       "vert_sat",  8'd255);
        run_one(win_corner(8'd10), "corner_mag", 8'd20);

        frame_start(8'd20, 1'b1);
        run_one(win_corner(8'd10), "bin_thr20", 8'd255);
        frame_start(8'd21, 1'b1);
        run_one(win_corner(8'd10), "bin_thr21", 8'd0);

        // Mid-frame threshold change must wait for the next vs rising edge.
        w = win_corner(8'd10);
        cur_de = 1'b1;
        tick();
        threshold = 8'd20;
        tick();
        cur_de = 1'b0;
        tick();
        check("midframe_a", 32'(bus.post_data), 32'd0);
        tick();
        check("midframe_b", 32'(bus.post_data), 32'd0);
        frame_start(8'd20, 1'b1);
        run_one(win_corner(8'd10), "next_frame", 8'd255);

        // Back-to-back windows, then a one-clock de gap.
        frame_start(8'd64, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w      = (i % 2 == 0) ? win_vert() : win_flat(8'd100);
            cur_de = 1'b1;
            tick();
            if (i >= 2) check("alternate", 32'(bus.post_data), ((i - 2) % 2 == 0) ? 32'd255 : 32'd0);
        end
        cur_de = 1'b0;
        tick();
        w      = win_vert();
        cur_de = 1'b1;
        tick();
        check("gap_prev_de", 32'(bus.post_de), 32'd1);
        tick();
        check("gap_de",   32'(bus.post_de),   32'd0);
        check("gap_data", 32'(bus.post_data), 32'd0);
        tick();
        check("gap_after_de",   32'(bus.post_de),   32'd1);
        check("gap_after_data", 32'(bus.post_data), 32'd255);

        // Randomized frames with random de, settings changes and occasional vs toggles.
        for (int f = 0; f < 6; f++) begin
            frame_start(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 60; i++) begin
                int kind;
                logic [7:0] base;
                kind = $urandom_range(0, 2);
                base = 8'($urandom_range(0, 200));
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) w[r][c] = rand_pix(kind, base);
                cur_de = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) threshold = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 15) == 0) bin_en = ~bin_en;
                if ($urandom_range(0, 29) == 0) cur_vs = ~cur_vs;
                tick();
            end
        end

        // Asynchronous reset mid-stream; settings fall back to defaults.
        frame_start(8'd200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w      = win_vert();
            cur_de = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vs",   32'(bus.post_vs),   32'd0);
        check("arst_de",   32'(bus.post_de),   32'd0);
        check("arst_data", 32'(bus.post_data), 32'd0);
        cur_vs = 1'b0;
        cur_de = 1'b0;
        w      = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_one(win_corner(8'd32), "post_rst_mag64", 8'd255);
        run_one(win_corner(8'd31), "post_rst_mag62", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
